dual_issue_scheduler: RTL and testbench

//  Per-cycle warp scheduler for the SM issue stage. Picks one ready warp (round-robin),

---
 rtl/dual_issue_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_issue_scheduler.sv
// Round-robin warp scheduler with ALU/FPU dual issue and a per-warp register scoreboard.
// Issue outputs are combinational; scoreboard, round-robin pointer and statistics are registered.
module dual_issue_scheduler #(
   parameter  int NUM_WARPS = 24,
   parameter  int NUM_REGS  = 64,
   localparam int WID       = $clog2(NUM_WARPS),
   localparam int RID       = $clog2(NUM_REGS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_WARPS*2-1:0]     ibuf_valid,
   input  logic [NUM_WARPS*2-1:0]     ibuf_unit,
   input  logic [NUM_WARPS*2-1:0]     ibuf_wr,
   input  logic [NUM_WARPS*6-1:0]     ibuf_src_en,
   input  logic [NUM_WARPS*2*RID-1:0] ibuf_rd,
   input  logic [NUM_WARPS*6*RID-1:0] ibuf_rs,
   input  logic [NUM_WARPS-1:0]       warp_active,
   input  logic                       alu_issue_ready,
   input  logic                       fpu_issue_ready,
   input  logic                       alu_wb_valid,
   input  logic [WID-1:0]             alu_wb_warp,
   input  logic [RID-1:0]             alu_wb_rd,
   input  logic                       fpu_wb_valid,
   input  logic [WID-1:0]             fpu_wb_warp,
   input  logic [RID-1:0]             fpu_wb_rd,
   input  logic                       sb_flush_valid,
   input  logic [WID-1:0]             sb_flush_warp,
   output logic                       alu_issue_valid,
   output logic                       fpu_issue_valid,
   output logic [WID-1:0]             issue_warp,
   output logic                       alu_issue_slot,
   output logic                       fpu_issue_slot,
   output logic [1:0]                 ibuf_pop_count,
   output logic [31:0]                stat_single,
   output logic [31:0]                stat_dual
);

   logic [NUM_REGS-1:0]  sb_q [NUM_WARPS];
   logic [NUM_REGS-1:0]  sb_d [NUM_WARPS];
   logic [WID-1:0]       rr_ptr_q, rr_ptr_d;
   logic [31:0]          stat_single_q, stat_single_d;
   logic [31:0]          stat_dual_q, stat_dual_d;
   logic [NUM_WARPS-1:0] cand_s, dual_ok_s;
   logic                 found_s, dual_s, unit0_s;
   logic [WID-1:0]       sel_s;

   function automatic logic slot_clear(input logic [NUM_REGS-1:0] row, input logic wr,
                                       input logic [RID-1:0] rd, input logic [2:0] en,
                                       input logic [3*RID-1:0] rs);
      logic ok;
      ok = ~(wr & row[rd]);
      for (int k = 0; k < 3; k++) begin
         if (en[k] && row[rs[k*RID +: RID]]) ok = 1'b0;
      end
      return ok;
   endfunction

   // RAW/WAW of slot1 against slot0's destination; WAR is deliberately ignored.
   function automatic logic pair_clear(input logic wr0, input logic [RID-1:0] rd0,
                                       input logic wr1, input logic [RID-1:0] rd1,
                                       input logic [2:0] en1, input logic [3*RID-1:0] rs1);
      logic ok;
      ok = ~(wr0 & wr1 & (rd1 == rd0));
      for (int k = 0; k < 3; k++) begin
         if (wr0 && en1[k] && (rs1[k*RID +: RID] == rd0)) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [WID-1:0] rr_idx(input logic [WID-1:0] ptr, input int i);
      int s;
      s = int'(ptr) + i;
      if (s >= NUM_WARPS) s = s - NUM_WARPS;
      return WID'(s);
   endfunction

   // Per-warp eligibility of slot0 and co-issue legality of slot1.
   always_comb begin
      cand_s    = '0;
      dual_ok_s = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         cand_s[w] = warp_active[w] && ibuf_valid[2*w]
                  && (ibuf_unit[2*w] ? fpu_issue_ready : alu_issue_ready)
                  && slot_clear(sb_q[w], ibuf_wr[2*w], ibuf_rd[2*w*RID +: RID],
                                ibuf_src_en[6*w +: 3], ibuf_rs[6*w*RID +: 3*RID]);
         dual_ok_s[w] = ibuf_valid[2*w+1] && (ibuf_unit[2*w+1] != ibuf_unit[2*w])
                  && (ibuf_unit[2*w+1] ? fpu_issue_ready : alu_issue_ready)
                  && slot_clear(sb_q[w], ibuf_wr[2*w+1], ibuf_rd[(2*w+1)*RID +: RID],
                                ibuf_src_en[6*w+3 +: 3], ibuf_rs[(6*w+3)*RID +: 3*RID])
                  && pair_clear(ibuf_wr[2*w], ibuf_rd[2*w*RID +: RID],
                                ibuf_wr[2*w+1], ibuf_rd[(2*w+1)*RID +: RID],
                                ibuf_src_en[6*w+3 +: 3], ibuf_rs[(6*w+3)*RID +: 3*RID]);
      end
   end

   // Round-robin pick: descending scan so the candidate nearest rr_ptr is written last.
   always_comb begin
      found_s = 1'b0;
      sel_s   = '0;
      for (int i = NUM_WARPS - 1; i >= 0; i--) begin
         if (cand_s[rr_idx(rr_ptr_q, i)]) begin
            found_s = 1'b1;
            sel_s   = rr_idx(rr_ptr_q, i);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Dispatch outputs for the selected warp.
   always_comb begin
      unit0_s = 1'b0;
      dual_s  = 1'b0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         if (found_s && (sel_s == WID'(w))) begin
            unit0_s = ibuf_unit[2*w];
            dual_s  = dual_ok_s[w];
         end else begin
            dual_s = dual_s;
         end
      end
      alu_issue_valid = found_s & (~unit0_s | dual_s);
      fpu_issue_valid = found_s & (unit0_s | dual_s);
      alu_issue_slot  = found_s & unit0_s & dual_s;
      fpu_issue_slot  = found_s & ~unit0_s & dual_s;
      issue_warp      = found_s ? sel_s : '0;
      if (!found_s)    ibuf_pop_count = 2'd0;
      else if (dual_s) ibuf_pop_count = 2'd2;
      else             ibuf_pop_count = 2'd1;
   end

   // Next state: clears (flush, writebacks) first, so issue-time sets win on the same edge.
   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         sb_d[w] = sb_q[w];
         if (sb_flush_valid && (sb_flush_warp == WID'(w))) sb_d[w] = '0;
         else sb_d[w] = sb_d[w];
         if (alu_wb_valid && (alu_wb_warp == WID'(w))) sb_d[w][alu_wb_rd] = 1'b0;
         else sb_d[w] = sb_d[w];
         if (fpu_wb_valid && (fpu_wb_warp == WID'(w))) sb_d[w][fpu_wb_rd] = 1'b0;
         else sb_d[w] = sb_d[w];
         if (found_s && (sel_s == WID'(w))) begin
            if (ibuf_wr[2*w]) sb_d[w][ibuf_rd[2*w*RID +: RID]] = 1'b1;
            else sb_d[w] = sb_d[w];
            if (dual_s && ibuf_wr[2*w+1]) sb_d[w][ibuf_rd[(2*w+1)*RID +: RID]] = 1'b1;
            else sb_d[w] = sb_d[w];
         end else begin
            sb_d[w] = sb_d[w];
         end
      end
      rr_ptr_d      = rr_ptr_q;
      stat_single_d = stat_single_q;
      stat_dual_d   = stat_dual_q;
      if (found_s) begin
         rr_ptr_d = (sel_s == WID'(NUM_WARPS - 1)) ? '0 : sel_s + WID'(1);
         if (dual_s) stat_dual_d   = stat_dual_q + 32'd1;
         else        stat_single_d = stat_single_q + 32'd1;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WARPS; w++) sb_q[w] <= '0;
         rr_ptr_q      <= '0;
         stat_single_q <= 32'd0;
         stat_dual_q   <= 32'd0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) sb_q[w] <= sb_d[w];
         rr_ptr_q      <= rr_ptr_d;
         stat_single_q <= stat_single_d;
         stat_dual_q   <= stat_dual_d;
      end
   end

   assign stat_single = stat_single_q;
   assign stat_dual   = stat_dual_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Bench for dual_issue_scheduler: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural scoreboard model.
module tb_dual_issue_scheduler;
   localparam int NW  = 24;
   localparam int NR  = 64;
   localparam int WID = 5;
   localparam int RID = 6;

   logic                  clk, rst_n;
   logic [NW*2-1:0]       ibuf_valid, ibuf_unit, ibuf_wr;
   logic [NW*6-1:0]       ibuf_src_en;
   logic [NW*2*RID-1:0]   ibuf_rd;
   logic [NW*6*RID-1:0]   ibuf_rs;
   logic [NW-1:0]         warp_active;
   logic                  alu_issue_ready, fpu_issue_ready;
   logic                  alu_wb_valid, fpu_wb_valid, sb_flush_valid;
   logic [WID-1:0]        alu_wb_warp, fpu_wb_warp, sb_flush_warp;
   logic [RID-1:0]        alu_wb_rd, fpu_wb_rd;
   logic                  alu_issue_valid, fpu_issue_valid, alu_issue_slot, fpu_issue_slot;
   logic [WID-1:0]        issue_warp;
   logic [1:0]            ibuf_pop_count;
   logic [31:0]           stat_single, stat_dual;

   dual_issue_scheduler #(.NUM_WARPS(NW), .NUM_REGS(NR)) dut (
      .clk(clk), .rst_n(rst_n),
      .ibuf_valid(ibuf_valid), .ibuf_unit(ibuf_unit), .ibuf_wr(ibuf_wr),
      .ibuf_src_en(ibuf_src_en), .ibuf_rd(ibuf_rd), .ibuf_rs(ibuf_rs),
      .warp_active(warp_active),
      .alu_issue_ready(alu_issue_ready), .fpu_issue_ready(fpu_issue_ready),
      .alu_wb_valid(alu_wb_valid), .alu_wb_warp(alu_wb_warp), .alu_wb_rd(alu_wb_rd),
      .fpu_wb_valid(fpu_wb_valid), .fpu_wb_warp(fpu_wb_warp), .fpu_wb_rd(fpu_wb_rd),
      .sb_flush_valid(sb_flush_valid), .sb_flush_warp(sb_flush_warp),
      .alu_issue_valid(alu_issue_valid), .fpu_issue_valid(fpu_issue_valid),
      .issue_warp(issue_warp), .alu_issue_slot(alu_issue_slot),
      .fpu_issue_slot(fpu_issue_slot), .ibuf_pop_count(ibuf_pop_count),
      .stat_single(stat_single), .stat_dual(stat_dual)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   bit          m_sb [NW][NR];
   int          m_ptr;
   logic [31:0] m_single, m_dual;
   bit          e_found, e_dual;
   int          e_warp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic int f_rd(int w, int s);
      return int'(ibuf_rd[(2*w+s)*RID +: RID]);
   endfunction
   function automatic int f_rs(int w, int s, int k);
      return int'(ibuf_rs[((2*w+s)*3+k)*RID +: RID]);
   endfunction
   function automatic bit f_ready(bit u);
      return u ? fpu_issue_ready : alu_issue_ready;
   endfunction

   // Registers a slot touches: its enabled sources plus its destination if it writes.
   function automatic bit m_free(int w, int s);
      int regs[$];
      for (int k = 0; k < 3; k++)
         if (ibuf_src_en[(2*w+s)*3+k]) regs.push_back(f_rs(w, s, k));
      if (ibuf_wr[2*w+s]) regs.push_back(f_rd(w, s));
      foreach (regs[i]) if (m_sb[w][regs[i]]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_reset();
      foreach (m_sb[w, r]) m_sb[w][r] = 1'b0;
      m_ptr = 0; m_single = 0; m_dual = 0;
   endtask

   task automatic m_eval();
      bit dep;
      int w, rd0;
      e_found = 0; e_dual = 0; e_warp = 0;
      for (int k = 0; k < NW; k++) begin
         w = (m_ptr + k) % NW;
         if (!e_found && warp_active[w] && ibuf_valid[2*w] &&
             f_ready(ibuf_unit[2*w]) && m_free(w, 0)) begin
            e_found = 1; e_warp = w;
         end
      end
      if (e_found) begin
         w = e_warp; dep = 0; rd0 = f_rd(w, 0);
         if (ibuf_wr[2*w]) begin
            for (int k = 0; k < 3; k++)
               if (ibuf_src_en[(2*w+1)*3+k] && f_rs(w, 1, k) == rd0) dep = 1;
            if (ibuf_wr[2*w+1] && f_rd(w, 1) == rd0) dep = 1;
         end
         e_dual = ibuf_valid[2*w+1] && (ibuf_unit[2*w+1] != ibuf_unit[2*w]) &&
                  f_ready(ibuf_unit[2*w+1]) && m_free(w, 1) && !dep;
      end
   endtask

   task automatic m_update();
      for (int r = 0; r < NR; r++)
         if (sb_flush_valid) m_sb[int'(sb_flush_warp)][r] = 1'b0;
      if (alu_wb_valid) m_sb[int'(alu_wb_warp)][int'(alu_wb_rd)] = 1'b0;
      if (fpu_wb_valid) m_sb[int'(fpu_wb_warp)][int'(fpu_wb_rd)] = 1'b0;
      if (e_found) begin
         if (ibuf_wr[2*e_warp]) m_sb[e_warp][f_rd(e_warp, 0)] = 1'b1;
         if (e_dual && ibuf_wr[2*e_warp+1]) m_sb[e_warp][f_rd(e_warp, 1)] = 1'b1;
         m_ptr = (e_warp + 1) % NW;
         if (e_dual) m_dual = m_dual + 1;
         else        m_single = m_single + 1;
      end
   endtask

   // Settle, evaluate the model and compare every DUT output against it.
   task automatic check_cycle();
      bit ea, ef, eas, efs;
      #1;
      m_eval();
      ea = 0; ef = 0; eas = 0; efs = 0;
      if (e_found) begin
         if (ibuf_unit[2*e_warp]) ef = 1; else ea = 1;
         if (e_dual) begin
            if (ibuf_unit[2*e_warp]) begin ea = 1; eas = 1; end
            else begin ef = 1; efs = 1; end
         end
      end
      chk("alu_issue_valid", alu_issue_valid, ea);
      chk("fpu_issue_valid", fpu_issue_valid, ef);
      chk("alu_issue_slot", alu_issue_slot, eas);
      chk("fpu_issue_slot", fpu_issue_slot, efs);
      chk("issue_warp", issue_warp, e_found ? e_warp : 0);
      chk("ibuf_pop_count", ibuf_pop_count, int'(e_found) + int'(e_dual));
      chk("stat_single", stat_single, m_single);
      chk("stat_dual", stat_dual, m_dual);
   endtask

   task automatic tick();
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      ibuf_valid = '0; ibuf_unit = '0; ibuf_wr = '0; ibuf_src_en = '0;
      ibuf_rd = '0; ibuf_rs = '0; warp_active = '0;
      alu_issue_ready = 1; fpu_issue_ready = 1;
      alu_wb_valid = 0; alu_wb_warp = '0; alu_wb_rd = '0;
      fpu_wb_valid = 0; fpu_wb_warp = '0; fpu_wb_rd = '0;
      sb_flush_valid = 0; sb_flush_warp = '0;
   endtask

   task automatic set_slot(int w, int s, bit v, bit u, bit wr, bit [2:0] en,
                           int rd, int r1, int r2, int r3);
      int j;
      j = 2*w + s;
      ibuf_valid[j] = v; ibuf_unit[j] = u; ibuf_wr[j] = wr;
      ibuf_src_en[j*3 +: 3] = en;
      ibuf_rd[j*RID +: RID] = RID'(rd);
      ibuf_rs[(j*3)*RID +: RID]   = RID'(r1);
      ibuf_rs[(j*3+1)*RID +: RID] = RID'(r2);
      ibuf_rs[(j*3+2)*RID +: RID] = RID'(r3);
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      m_reset();
      #1;
      chk("reset_stat_single", stat_single, 32'd0);
      chk("reset_stat_dual", stat_dual, 32'd0);
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      int ww, rr;
      rst_n = 0;
      clear_inputs();
      m_reset();
      #1;
      chk("por_alu_valid", alu_issue_valid, 0);
      chk("por_fpu_valid", fpu_issue_valid, 0);
      chk("por_pop", ibuf_pop_count, 0);
      chk("por_stat_dual", stat_dual, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1;

      // Dual issue ADD R5 (ALU) + FADD R6 (FPU)
      warp_active[0] = 1;
      set_slot(0, 0, 1, 0, 1, 3'b011, 5, 1, 2, 0);
      set_slot(0, 1, 1, 1, 1, 3'b011, 6, 3, 4, 0);
      check_cycle();
      chk("t1_alu", alu_issue_valid, 1); chk("t1_fpu", fpu_issue_valid, 1);
      chk("t1_pop", ibuf_pop_count, 2); chk("t1_fslot", fpu_issue_slot, 1);
      tick();
      chk("t1_stat_dual", stat_dual, 1);
      set_slot(0, 0, 1, 0, 0, 3'b001, 0, 6, 0, 0);
      set_slot(0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0);
      check_cycle();
      chk("t1_r6_blocked", ibuf_pop_count, 0);
      tick();

      // RAW inside the pair, then ITOF waits for the ALU writeback of R3
      do_reset();
      warp_active[0] = 1;
      set_slot(0, 0, 1, 0, 1, 3'b001, 3, 1, 0, 0);
      set_slot(0, 1, 1, 1, 1, 3'b001, 4, 3, 0, 0);
      check_cycle();
      chk("t2_pop_raw", ibuf_pop_count, 1); chk("t2_fpu", fpu_issue_valid, 0);
      tick();
      set_slot(0, 0, 1, 1, 1, 3'b001, 4, 3, 0, 0);
      set_slot(0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0);
      check_cycle();
      chk("t2_wait", ibuf_pop_count, 0);
      tick();
      alu_wb_valid = 1; alu_wb_warp = 0; alu_wb_rd = 3;
      check_cycle();
      chk("t2_no_bypass", ibuf_pop_count, 0);
      tick();
      alu_wb_valid = 0;
      check_cycle();
      chk("t2_itof_fpu", fpu_issue_valid, 1); chk("t2_itof_pop", ibuf_pop_count, 1);
      tick();
      chk("t2_stat_single", stat_single, 2);

      // Same-unit pair: single issue twice
      do_reset();
      warp_active[0] = 1;
      set_slot(0, 0, 1, 0, 1, 3'b001, 1, 2, 0, 0);
      set_slot(0, 1, 1, 0, 1, 3'b001, 3, 4, 0, 0);
      check_cycle();
      chk("t3_pop_a", ibuf_pop_count, 1);
      tick();
      set_slot(0, 0, 1, 0, 1, 3'b001, 3, 4, 0, 0);
      set_slot(0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0);
      check_cycle();
      chk("t3_pop_b", ibuf_pop_count, 1);
      tick();

      // Round-robin over W0..W2
      do_reset();
      for (int w = 0; w < 3; w++) begin
         warp_active[w] = 1;
         set_slot(w, 0, 1, 0, 0, 3'b011, 0, 1, 2, 0);
      end
      for (int c = 0; c < 4; c++) begin
         check_cycle();
         chk("t4_rr_warp", issue_warp, c % 3);
         tick();
      end

      // FPU not ready: nothing issues, stats hold
      do_reset();
      warp_active[0] = 1;
      set_slot(0, 0, 1, 1, 0, 3'b011, 0, 1, 2, 0);
      fpu_issue_ready = 0;
      check_cycle();
      chk("t5_stall_fpu", fpu_issue_valid, 0);
      tick();
      chk("t5_stat_hold", stat_single, 0);
      fpu_issue_ready = 1;
      check_cycle();
      chk("t5_go_fpu", fpu_issue_valid, 1);
      tick();

      // Pointer wrap: W0 and W23 alternate
      do_reset();
      warp_active[0] = 1; warp_active[23] = 1;
      set_slot(0, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0);
      set_slot(23, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         check_cycle();
         chk("t7_wrap_warp", issue_warp, (c == 1) ? 23 : 0);
         tick();
      end

      // Issue set beats same-edge writeback clear and flush
      do_reset();
      warp_active[0] = 1;
      set_slot(0, 0, 1, 0, 1, 3'b000, 5, 0, 0, 0);
      alu_wb_valid = 1; alu_wb_rd = 5; fpu_wb_valid = 1; fpu_wb_rd = 5;
      sb_flush_valid = 1;
      check_cycle();
      tick();
      alu_wb_valid = 0; fpu_wb_valid = 0; sb_flush_valid = 0;
      set_slot(0, 0, 1, 0, 0, 3'b001, 0, 5, 0, 0);
      check_cycle();
      chk("t8_set_wins", ibuf_pop_count, 0);
      tick();

      // Mid-run reset clears sb[3][7] and the pointer
      do_reset();
      warp_active[3] = 1;
      set_slot(3, 0, 1, 0, 1, 3'b000, 7, 0, 0, 0);
      check_cycle();
      tick();
      set_slot(3, 0, 1, 0, 1, 3'b001, 8, 7, 0, 0);
      check_cycle();
      chk("t6_r7_blocked", ibuf_pop_count, 0);
      tick();
      rst_n = 0;
      m_reset();
      #1;
      chk("t6_stat_cleared", stat_single, 0);
      @(negedge clk);
      rst_n = 1;
      warp_active[5] = 1;
      set_slot(5, 0, 1, 0, 0, 3'b000, 0, 0, 0, 0);
      check_cycle();
      chk("t6_w3_issues", issue_warp, 3);
      chk("t6_pop", ibuf_pop_count, 1);
      tick();

      // Randomized traffic with a small register window to provoke hazards
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         warp_active = 24'($urandom);
         for (int w = 0; w < NW; w++)
            for (int s = 0; s < 2; s++)
               set_slot(w, s, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                        3'($urandom), $urandom_range(0, 7), $urandom_range(0, 7),
                        $urandom_range(0, 7), $urandom_range(0, 7));
         alu_issue_ready = $urandom_range(0, 3) != 0;
         fpu_issue_ready = $urandom_range(0, 3) != 0;
         for (int u = 0; u < 2; u++) begin
            ww = $urandom_range(0, NW - 1);
            rr = $urandom_range(0, 7);
            for (int r = 0; r < 8; r++) if (m_sb[ww][r] && $urandom_range(0, 1) == 1) rr = r;
            if (u == 0) begin
               alu_wb_valid = $urandom_range(0, 3) != 0;
               alu_wb_warp = WID'(ww); alu_wb_rd = RID'(rr);
            end else if ($urandom_range(0, 7) == 0) begin
               fpu_wb_valid = 1; fpu_wb_warp = alu_wb_warp; fpu_wb_rd = alu_wb_rd;
            end else begin
               fpu_wb_valid = $urandom_range(0, 3) != 0;
               fpu_wb_warp = WID'(ww); fpu_wb_rd = RID'(rr);
            end
         end
         sb_flush_valid = $urandom_range(0, 63) == 0;
         sb_flush_warp  = WID'($urandom_range(0, NW - 1));
         check_cycle();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
